// File: rtl/fetch_pkg.sv
// Shared encodings and state type for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int SIZE_PC_DEF = 9;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_JUMP   = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b10;
    localparam logic [1:0] SEL_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_dec.sv
// Combinational decode of the next-PC select into a redirect flag and its target.
module fetch_redirect_dec
    import fetch_pkg::*;
#(
    parameter int SIZE_PC = SIZE_PC_DEF
) (
    input  logic [1:0]       sel_dir,
    input  logic             flag_branch,
    input  logic [SIZE_PC:0] pc_jump,
    input  logic [SIZE_PC:0] pc_branch,
    output logic             redirect,
    output logic [SIZE_PC:0] target
);

    always_comb begin
        redirect = 1'b0;
        target   = pc_branch;
        case (sel_dir)
            SEL_JUMP: begin
                redirect = 1'b1;
                target   = pc_jump;
            end
            SEL_BRANCH: redirect = flag_branch;
            default:    redirect = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, drives a 1-cycle-latency instruction memory and
// presents instructions to decode through a valid/ready handshake with a skid register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int               SIZE_PC  = SIZE_PC_DEF,
    parameter logic [SIZE_PC:0] RESET_PC = '0,
    parameter int               INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sel_dir,
    input  logic              flag_branch,
    input  logic [SIZE_PC:0]  pc_jump,
    input  logic [SIZE_PC:0]  pc_branch,
    output logic [SIZE_PC:0]  imem_addr,
    output logic              imem_en,
    input  logic [INST_W-1:0] imem_q,
    output logic [INST_W-1:0] inst_out,
    output logic [SIZE_PC:0]  inst_pc,
    output logic              inst_valid,
    input  logic              id_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       perf_stall,
    output logic [15:0]       perf_redir,
    output logic              sel_err
`endif
);

    localparam logic [SIZE_PC:0] PC_ONE = {{SIZE_PC{1'b0}}, 1'b1};

    // Handshake: decode takes inst_out/inst_pc on a cycle with inst_valid & id_ready;
    // while inst_valid & !id_ready they stay stable unless a redirect squashes them.
    fetch_state_e      state_q, state_d;
    logic [SIZE_PC:0]  pc_q, pc_d;
    logic              infl_q, infl_d;
    logic [SIZE_PC:0]  infl_pc_q, infl_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [SIZE_PC:0]  skid_pc_q, skid_pc_d;
    logic              redirect;
    logic [SIZE_PC:0]  target;
    logic              issue;

    fetch_redirect_dec #(.SIZE_PC(SIZE_PC)) u_redirect_dec (
        .sel_dir     (sel_dir),
        .flag_branch (flag_branch),
        .pc_jump     (pc_jump),
        .pc_branch   (pc_branch),
        .redirect    (redirect),
        .target      (target)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        infl_d      = 1'b0;
        infl_pc_d   = infl_pc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        issue       = 1'b0;
        inst_out    = '0;
        inst_pc     = '0;
        inst_valid  = 1'b0;
        imem_addr   = redirect ? target : pc_q;

        case (state_q)
            BOOT: begin
                issue   = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                inst_out   = imem_q;
                inst_pc    = infl_pc_q;
                inst_valid = infl_q & ~redirect;
                if (redirect || !infl_q || id_ready) begin
                    issue = 1'b1;
                end else begin
                    // Park the stalled word so the memory port is free to idle.
                    skid_inst_d = imem_q;
                    skid_pc_d   = infl_pc_q;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                inst_out   = skid_inst_q;
                inst_pc    = skid_pc_q;
                inst_valid = ~redirect;
                if (redirect || id_ready) begin
                    issue   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase

        if (redirect) begin
            state_d     = FETCH;
            skid_inst_d = '0;
            skid_pc_d   = '0;
        end

        if (issue) begin
            pc_d      = imem_addr + PC_ONE;
            infl_pc_d = imem_addr;
            infl_d    = 1'b1;
        end

        if (!rst_n) begin
            inst_out   = '0;
            inst_pc    = '0;
            inst_valid = 1'b0;
        end
        imem_en = issue & rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            infl_q      <= 1'b0;
            infl_pc_q   <= '0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            infl_q      <= infl_d;
            infl_pc_q   <= infl_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_redir_q, perf_redir_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_redir_d = perf_redir_q;
        if (inst_valid && !id_ready && perf_stall_q != 16'hFFFF) begin
            perf_stall_d = perf_stall_q + 16'd1;
        end
        if (redirect && perf_redir_q != 16'hFFFF) begin
            perf_redir_d = perf_redir_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_redir_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_redir = perf_redir_q;
    assign sel_err    = rst_n & (sel_dir == SEL_RSVD);
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: synchronous memory model, per-scenario
// tasks with inline checks, and an accept-side scoreboard of expected PCs.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel_dir;
    logic        flag_branch;
    logic [9:0]  pc_jump;
    logic [9:0]  pc_branch;
    logic [9:0]  imem_addr;
    logic        imem_en;
    logic [31:0] imem_q;
    logic [31:0] inst_out;
    logic [9:0]  inst_pc;
    logic        inst_valid;
    logic        id_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_stall;
    logic [15:0] perf_redir;
    logic        sel_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    fetch_sequencer #(.SIZE_PC(9), .RESET_PC(10'h000), .INST_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_dir     (sel_dir),
        .flag_branch (flag_branch),
        .pc_jump     (pc_jump),
        .pc_branch   (pc_branch),
        .imem_addr   (imem_addr),
        .imem_en     (imem_en),
        .imem_q      (imem_q),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .id_ready    (id_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall  (perf_stall),
        .perf_redir  (perf_redir),
        .sel_err     (sel_err)
`endif
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] inst_of(input logic [9:0] a);
        return {12'hABC, 10'h000, a};
    endfunction

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_en) imem_q <= inst_of(imem_addr);
    end

    // Scoreboard: every accepted instruction must match the next expected PC.
    always @(negedge clk) begin
        if (inst_valid && id_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL accept_unexpected: got pc=%h inst=%h, none expected", inst_pc, inst_out);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (inst_pc !== e || inst_out !== inst_of(e)) begin
                    errors++;
                    $display("FAIL accept: got pc=%h inst=%h, expected pc=%h inst=%h",
                             inst_pc, inst_out, e, inst_of(e));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; id_ready = 1'b1; sel_dir = 2'b00; flag_branch = 1'b0;
        pc_jump = '0; pc_branch = '0;
        cyc(); cyc(); cyc();
        #1;
        checks++;
        if (inst_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 10'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b inst=%h pc=%h, expected 0/0/0", inst_valid, inst_out, inst_pc);
        end
        checks++;
        if (imem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_imem_en: got %b expected 0", imem_en);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 10'h000 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_issue: en=%b addr=%h valid=%b, expected 1/000/0", imem_en, imem_addr, inst_valid);
        end
        cyc();
    endtask

    task automatic test_seq();
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(10'(k));
            #1;
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 10'(k) || imem_addr !== 10'(k + 1)) begin
                errors++;
                $display("FAIL seq_%0d: valid=%b pc=%h addr=%h, expected 1/%h/%h",
                         k, inst_valid, inst_pc, imem_addr, 10'(k), 10'(k + 1));
            end
            cyc();
        end
    endtask

    task automatic test_jump();
        sel_dir = 2'b01; pc_jump = 10'h100;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 10'h100) begin
            errors++;
            $display("FAIL jump_squash: valid=%b en=%b addr=%h, expected 0/1/100", inst_valid, imem_en, imem_addr);
        end
        cyc();
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_redir !== 16'd1) begin
            errors++;
            $display("FAIL perf_redir_1: got %0d expected 1", perf_redir);
        end
`endif
        sel_dir = 2'b00;
        exp_q.push_back(10'h100);
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'h100) begin
            errors++;
            $display("FAIL jump_target: valid=%b pc=%h, expected 1/100", inst_valid, inst_pc);
        end
        cyc();
        exp_q.push_back(10'h101);
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'h101) begin
            errors++;
            $display("FAIL jump_next: valid=%b pc=%h, expected 1/101", inst_valid, inst_pc);
        end
        cyc();
    endtask

    task automatic test_branch();
        sel_dir = 2'b10; flag_branch = 1'b0; pc_branch = 10'h040;
        exp_q.push_back(10'h102);
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'h102 || imem_addr !== 10'h103) begin
            errors++;
            $display("FAIL branch_not_taken: valid=%b pc=%h addr=%h, expected 1/102/103", inst_valid, inst_pc, imem_addr);
        end
        cyc();
        flag_branch = 1'b1;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_addr !== 10'h040) begin
            errors++;
            $display("FAIL branch_taken: valid=%b addr=%h, expected 0/040", inst_valid, imem_addr);
        end
        cyc();
        sel_dir = 2'b00; flag_branch = 1'b0;
        exp_q.push_back(10'h040);
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'h040) begin
            errors++;
            $display("FAIL branch_target: valid=%b pc=%h, expected 1/040", inst_valid, inst_pc);
        end
        cyc();
    endtask

    task automatic test_stall();
        sel_dir = 2'b01; pc_jump = 10'h006;
        #1;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_setup_squash: valid=%b expected 0", inst_valid);
        end
        cyc();
        sel_dir = 2'b00;
        exp_q.push_back(10'h006);
        cyc();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 10'h007 || inst_out !== inst_of(10'h007) || imem_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold_%0d: valid=%b pc=%h inst=%h en=%b, expected 1/007/%h/0",
                         i, inst_valid, inst_pc, inst_out, imem_en, inst_of(10'h007));
            end
            cyc();
        end
        id_ready = 1'b1;
        exp_q.push_back(10'h007);
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'h007 || imem_en !== 1'b1 || imem_addr !== 10'h008) begin
            errors++;
            $display("FAIL stall_release: valid=%b pc=%h en=%b addr=%h, expected 1/007/1/008",
                     inst_valid, inst_pc, imem_en, imem_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_stall !== 16'd3) begin
            errors++;
            $display("FAIL perf_stall_3: got %0d expected 3", perf_stall);
        end
`endif
        cyc();
    endtask

    task automatic test_hold_redirect();
        id_ready = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'h008) begin
            errors++;
            $display("FAIL after_stall: valid=%b pc=%h, expected 1/008", inst_valid, inst_pc);
        end
        cyc();
        sel_dir = 2'b01; pc_jump = 10'h200;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 10'h200) begin
            errors++;
            $display("FAIL hold_jump: valid=%b en=%b addr=%h, expected 0/1/200", inst_valid, imem_en, imem_addr);
        end
        cyc();
        sel_dir = 2'b00; id_ready = 1'b1;
        exp_q.push_back(10'h200);
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'h200) begin
            errors++;
            $display("FAIL hold_jump_target: valid=%b pc=%h, expected 1/200", inst_valid, inst_pc);
        end
        cyc();
    endtask

    task automatic test_hold_reset();
        id_ready = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_en !== 1'b0) begin
            errors++;
            $display("FAIL hold_reset_assert: valid=%b en=%b, expected 0/0", inst_valid, imem_en);
        end
        cyc();
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_en !== 1'b1 || imem_addr !== 10'h000 || inst_valid !== 1'b0 || inst_pc !== 10'h000) begin
            errors++;
            $display("FAIL hold_reset_boot: en=%b addr=%h valid=%b pc=%h, expected 1/000/0/000",
                     imem_en, imem_addr, inst_valid, inst_pc);
        end
        cyc();
        id_ready = 1'b1;
        exp_q.push_back(10'h000);
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'h000) begin
            errors++;
            $display("FAIL hold_reset_first: valid=%b pc=%h, expected 1/000", inst_valid, inst_pc);
        end
        cyc();
    endtask

    task automatic test_wrap();
        sel_dir = 2'b01; pc_jump = 10'h3FE;
        cyc();
        sel_dir = 2'b11;
        exp_q.push_back(10'h3FE);
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'h3FE || imem_addr !== 10'h3FF) begin
            errors++;
            $display("FAIL reserved_seq: valid=%b pc=%h addr=%h, expected 1/3fe/3ff", inst_valid, inst_pc, imem_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err: got %b expected 1", sel_err);
        end
`endif
        cyc();
        sel_dir = 2'b00;
        exp_q.push_back(10'h3FF);
        #1;
        checks++;
        if (inst_pc !== 10'h3FF || imem_addr !== 10'h000) begin
            errors++;
            $display("FAIL wrap_addr: pc=%h addr=%h, expected 3ff/000", inst_pc, imem_addr);
        end
        cyc();
        exp_q.push_back(10'h000);
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'h000) begin
            errors++;
            $display("FAIL wrap_pc: valid=%b pc=%h, expected 1/000", inst_valid, inst_pc);
        end
        cyc();
        id_ready = 1'b0;
        cyc();
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected instructions never accepted, expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; id_ready = 1'b0; sel_dir = 2'b00; flag_branch = 1'b0;
        pc_jump = '0; pc_branch = '0;
        test_reset();
        test_seq();
        test_jump();
        test_branch();
        test_stall();
        test_hold_redirect();
        test_hold_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
